// File: rtl/wb_select_stage.sv
// Writeback select stage: picks the result source, aligns and extends loads,
// flags misaligned loads and holds one bundle behind a valid/ready handshake.
`timescale 1ns/1ps
module wb_select_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 9,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [1:0]        res_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        byte_off,
  input  logic [2:0]        funct3,
  input  logic [PC_W-1:0]   pc_plus4,
  input  logic [DATA_W-1:0] imm,
  input  logic [RA_W-1:0]   rd_addr,
  input  logic              reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [RA_W-1:0]   wb_rd,
  output logic              wb_we,
  output logic              wb_misalign
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [15:0]       lane;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] pc_ext;
  logic [DATA_W-1:0] sel_data;
  logic              misalign;
  logic              we_next;
  logic              we_q;
  logic              capture;

  // The stage is free when empty or when the held bundle leaves this cycle.
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Only the low 16 bits of the shifted word are ever needed for sub-word loads.
  assign lane = 16'(mem_rdata[31:0] >> {byte_off, 3'b000});

  // Extend the addressed byte/half; unknown load types fall back to a full word.
  always_comb begin
    load_data = mem_rdata;
    case (funct3)
      F3_LB:   load_data = {{(DATA_W-8){lane[7]}}, lane[7:0]};
      F3_LH:   load_data = {{(DATA_W-16){lane[15]}}, lane[15:0]};
      F3_LW:   load_data = mem_rdata;
      F3_LBU:  load_data = {{(DATA_W-8){1'b0}}, lane[7:0]};
      F3_LHU:  load_data = {{(DATA_W-16){1'b0}}, lane[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  // Zero-extend PC+4; written as a slice so PC_W == DATA_W is still legal.
  always_comb begin
    pc_ext             = '0;
    pc_ext[PC_W-1:0]   = pc_plus4;
  end

  // Misalignment only matters for halfword and word loads.
  always_comb begin
    misalign = 1'b0;
    if (res_sel == SEL_LOAD) begin
      if ((funct3 == F3_LH || funct3 == F3_LHU) && byte_off[0])
        misalign = 1'b1;
      else if (funct3 == F3_LW && byte_off != 2'b00)
        misalign = 1'b1;
    end
  end

  // Result source mux.
  always_comb begin
    sel_data = alu_result;
    case (res_sel)
      SEL_ALU:  sel_data = alu_result;
      SEL_LOAD: sel_data = load_data;
      SEL_PC4:  sel_data = pc_ext;
      SEL_IMM:  sel_data = imm;
      default:  sel_data = alu_result;
    endcase
  end

  // A misaligned load still reports its data but must never reach the register file.
  assign we_next = reg_write && (rd_addr != '0) && !misalign;

  // Single output register; reset beats flush, flush beats capture, capture beats drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_misalign <= 1'b0;
      we_q        <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      wb_data     <= sel_data;
      wb_rd       <= rd_addr;
      wb_misalign <= misalign;
      we_q        <= we_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign wb_we = out_valid && we_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Scoreboard bench for wb_select_stage: stimulus pushes expected bundles from
// a transaction-level reference; a negedge monitor pops them on handshake.
`timescale 1ns/1ps
module tb_wb_select_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [1:0]  res_sel;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic [1:0]  byte_off;
  logic [2:0]  funct3;
  logic [8:0]  pc_plus4;
  logic [31:0] imm;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic        wb_misalign;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        mis;
  } exp_t;

  exp_t q[$];
  bit   mfull;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wb_select_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .res_sel(res_sel), .alu_result(alu_result),
    .mem_rdata(mem_rdata), .byte_off(byte_off), .funct3(funct3),
    .pc_plus4(pc_plus4), .imm(imm), .rd_addr(rd_addr), .reg_write(reg_write),
    .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_misalign(wb_misalign)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference: what the bundle on the inputs should produce once captured.
  function automatic exp_t ref_bundle();
    exp_t        e;
    int unsigned sh, b, h;
    bit          mis;
    sh  = mem_rdata >> (8 * int'(byte_off));
    b   = sh % 256;
    h   = sh % 65536;
    mis = 0;
    case (res_sel)
      2'd0: e.data = alu_result;
      2'd2: e.data = 32'(pc_plus4);
      2'd3: e.data = imm;
      default: begin
        case (funct3)
          3'd0:    e.data = (b >= 128) ? b + 32'hFFFF_FF00 : b;
          3'd1:    e.data = (h >= 32768) ? h + 32'hFFFF_0000 : h;
          3'd4:    e.data = b;
          3'd5:    e.data = h;
          default: e.data = mem_rdata;
        endcase
        if ((funct3 == 3'd1 || funct3 == 3'd5) && (byte_off % 2 == 1)) mis = 1;
        if (funct3 == 3'd2 && byte_off != 0) mis = 1;
      end
    endcase
    e.rd  = rd_addr;
    e.mis = mis;
    e.we  = reg_write && (rd_addr != 0) && !mis;
    return e;
  endfunction

  // Advance one clock, updating the transaction model with what the DUT just saw.
  task automatic cycle();
    bit rdy;
    @(posedge clk);
    if (reset) begin
      q.delete();
      mfull = 0;
    end else if (flush) begin
      if (mfull && q.size() > 0) void'(q.pop_front());
      mfull = 0;
    end else begin
      rdy = !mfull || out_ready;
      if (in_valid && rdy) begin
        q.push_back(ref_bundle());
        mfull = 1;
      end else if (mfull && out_ready) begin
        mfull = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; res_sel = 0; alu_result = 0; mem_rdata = 0;
    byte_off = 0; funct3 = 0; pc_plus4 = 0; imm = 0; rd_addr = 0;
    reg_write = 0; out_ready = 1;
  endtask

  // Monitor: handshake pops and compares; also checks ready/valid and hold stability.
  exp_t        pe;
  bit          prev_hold = 0;
  logic [31:0] prev_data;
  logic [4:0]  prev_rd;
  logic        prev_we, prev_mis;
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", in_ready, !mfull || out_ready);
      chk("out_valid", out_valid, mfull);
      if (!out_valid) chk("we_idle", wb_we, 0);
      if (prev_hold) begin
        chk("hold_data", wb_data, prev_data);
        chk("hold_rd", wb_rd, prev_rd);
        chk("hold_we", wb_we, prev_we);
        chk("hold_mis", wb_misalign, prev_mis);
      end
      if (out_valid && out_ready && !flush) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_empty actual=valid_output required=no_output");
        end else begin
          pe = q.pop_front();
          chk("sb_data", wb_data, pe.data);
          chk("sb_rd", wb_rd, pe.rd);
          chk("sb_we", wb_we, pe.we);
          chk("sb_mis", wb_misalign, pe.mis);
        end
      end
    end
    prev_hold = !reset && out_valid && !out_ready && !flush;
    prev_data = wb_data; prev_rd = wb_rd; prev_we = wb_we; prev_mis = wb_misalign;
  end

  initial begin
    idle();
    reset = 1;
    cycle(); cycle();
    reset = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_rd", wb_rd, 0);
    chk("rst_we", wb_we, 0);
    chk("rst_mis", wb_misalign, 0);
    chk("rst_ready", in_ready, 1);

    // Signed byte load from lane 2.
    in_valid = 1; res_sel = 2'b01; funct3 = 3'b000; byte_off = 2;
    mem_rdata = 32'h12F4_5678; rd_addr = 5; reg_write = 1;
    cycle();
    chk("lb_data", wb_data, 32'hFFFF_FFF4);
    chk("lb_we", wb_we, 1);
    chk("lb_rd", wb_rd, 5);

    // PC+4 zero extension.
    res_sel = 2'b10; pc_plus4 = 9'h1FC;
    cycle();
    chk("pc4_data", wb_data, 32'h0000_01FC);

    // Misaligned halfword.
    res_sel = 2'b01; funct3 = 3'b001; byte_off = 1; rd_addr = 7; reg_write = 1;
    cycle();
    chk("mis_flag", wb_misalign, 1);
    chk("mis_we", wb_we, 0);
    chk("mis_valid", out_valid, 1);

    // Backpressure: 0xA held while 0xB waits.
    idle(); in_valid = 1; alu_result = 32'hA; rd_addr = 1; reg_write = 1;
    cycle();
    out_ready = 0; alu_result = 32'hB;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_ready", in_ready, 0);
      chk("bp_data", wb_data, 32'hA);
    end
    out_ready = 1;
    cycle();
    chk("bp_next", wb_data, 32'hB);

    // Flush wins over capture.
    alu_result = 32'hC; flush = 1;
    cycle();
    chk("fl_valid", out_valid, 0);
    chk("fl_we", wb_we, 0);
    flush = 0;

    // x0 is never written.
    rd_addr = 0; reg_write = 1; alu_result = 32'h55;
    cycle();
    chk("x0_we", wb_we, 0);
    chk("x0_valid", out_valid, 1);

    // Reset while a bundle is stalled.
    rd_addr = 3; out_ready = 0;
    cycle();
    reset = 1;
    cycle();
    chk("rmid_valid", out_valid, 0);
    chk("rmid_data", wb_data, 0);
    chk("rmid_rd", wb_rd, 0);
    chk("rmid_we", wb_we, 0);
    chk("rmid_mis", wb_misalign, 0);
    chk("rmid_ready", in_ready, 1);
    reset = 0; idle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      in_valid   = ($urandom_range(0, 99) < 70);
      out_ready  = ($urandom_range(0, 99) < 70);
      flush      = ($urandom_range(0, 99) < 5);
      reset      = ($urandom_range(0, 199) < 2);
      res_sel    = 2'($urandom_range(0, 3));
      alu_result = $urandom;
      mem_rdata  = $urandom;
      imm        = $urandom;
      pc_plus4   = 9'($urandom);
      byte_off   = 2'($urandom_range(0, 3));
      funct3     = 3'($urandom_range(0, 7));
      if (funct3 == 3'd3 || funct3 >= 3'd6) byte_off = 0;
      rd_addr    = 5'($urandom);
      reg_write  = ($urandom_range(0, 3) != 0);
      cycle();
    end

    reset = 0; idle();
    for (int i = 0; i < 3; i++) cycle();
    chk("drain_queue", q.size(), 0);
    chk("drain_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
